// File: rtl/game_pkg.sv
// Shared types and widths for the duck-game flow controller and its score counter.
// Pure declarations; no logic and no latency.
// No handshakes.
package game_pkg;

    typedef enum logic [1:0] {
        START,
        PLAY,
        GAMEOVER
    } game_state_t;

    typedef logic [3:0] bcd_t;

    localparam int LIVES_W     = 4;
    localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score that adds 0, 1 or 2 per cycle and saturates at 99.
// Latency: increments and clear show on the outputs one clk after they are sampled.
// No backpressure: every increment presented is applied, and increments past 99 are dropped.
module bcd_score_counter
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc1,
    input  logic inc2,
    output bcd_t score_1,
    output bcd_t score_10
);

    bcd_t       units_q, units_d;
    bcd_t       tens_q, tens_d;
    logic [4:0] units_sum;

    always_comb begin
        units_d   = units_q;
        tens_d    = tens_q;
        units_sum = {1'b0, units_q} + {4'd0, inc1} + {4'd0, inc2};
        if (clear) begin
            units_d = '0;
            tens_d  = '0;
        end else if (units_sum > 5'd9) begin
            // A carry out of 9x would pass 99, so pin the display at 99 instead.
            if (tens_q == 4'd9) begin
                units_d = 4'd9;
            end else begin
                units_d = units_sum[3:0] - 4'd10;
                tens_d  = tens_q + 4'd1;
            end
        end else begin
            units_d = units_sum[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units_q <= '0;
            tens_q  <= '0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign score_1  = units_q;
    assign score_10 = tens_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: title -> play -> game-over -> title, with score, lives and duck respawn.
// Latency: key/frame inputs act 2 Clk after sync; hit/escape affect outputs the next Clk.
// No backpressure: events on a dead duck, keys in PLAY and early keys in GAMEOVER are dropped.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int GAMEOVER_HOLD = 120,
    parameter int RESPAWN_DELAY = 30
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               start_key,
    input  logic               hit1,
    input  logic               hit2,
    input  logic               escape1,
    input  logic               escape2,
    output logic               is_start,
    output logic               is_gameover,
    output logic               is_home,
    output logic [LIVES_W-1:0] lives,
    output logic [3:0]         is_score_1,
    output logic [3:0]         is_score_10,
    output logic               respawn1,
    output logic               respawn2,
    output logic               duck_en1,
    output logic               duck_en2
);

    logic [1:0] key_sync_q, key_sync_d;
    logic [1:0] frame_sync_q, frame_sync_d;
    logic       key_prev_q, key_prev_d;
    logic       frame_prev_q, frame_prev_d;
    logic       key_evt, frame_tick;

    game_state_t                 state_q, state_d;
    logic                        is_start_q, is_start_d;
    logic                        is_gameover_q, is_gameover_d;
    logic                        is_home_q, is_home_d;
    logic [LIVES_W-1:0]          lives_q, lives_d;
    logic [FRAME_CNT_W-1:0]      hold_q, hold_d;
    logic [1:0][FRAME_CNT_W-1:0] delay_q, delay_d;
    logic [1:0]                  duck_en_q, duck_en_d;
    logic [1:0]                  respawn_q, respawn_d;

    logic [1:0] hit_v, esc_v, score_inc;
    logic [1:0] lost;
    logic       score_clr;
    bcd_t       score_1, score_10;

    assign hit_v = {hit2, hit1};
    assign esc_v = {escape2, escape1};

    always_comb begin
        key_sync_d   = {key_sync_q[0], start_key};
        frame_sync_d = {frame_sync_q[0], frame_clk};
        key_prev_d   = key_sync_q[1];
        frame_prev_d = frame_sync_q[1];
    end

    assign key_evt    = key_sync_q[1] & ~key_prev_q;
    assign frame_tick = frame_sync_q[1] & ~frame_prev_q;

    always_comb begin
        state_d       = state_q;
        is_start_d    = is_start_q;
        is_gameover_d = is_gameover_q;
        is_home_d     = is_home_q;
        lives_d       = lives_q;
        hold_d        = hold_q;
        delay_d       = delay_q;
        duck_en_d     = duck_en_q;
        respawn_d     = '0;
        score_inc     = '0;
        score_clr     = 1'b0;
        lost          = '0;
        case (state_q)
            START: begin
                if (key_evt) begin
                    state_d    = PLAY;
                    is_start_d = 1'b0;
                    lives_d    = LIVES_W'(LIVES_INIT);
                    score_clr  = 1'b1;
                    delay_d    = '0;
                    duck_en_d  = 2'b11;
                    respawn_d  = 2'b11;
                end
            end
            PLAY: begin
                // Lives are judged on the registered count, so the last escape
                // is visible for one cycle before the overlay appears.
                if (lives_q == '0) begin
                    state_d       = GAMEOVER;
                    is_gameover_d = 1'b1;
                    is_home_d     = 1'b1;
                    hold_d        = FRAME_CNT_W'(GAMEOVER_HOLD);
                    delay_d       = '0;
                    duck_en_d     = '0;
                end else begin
                    for (int n = 0; n < 2; n++) begin
                        if (duck_en_q[n]) begin
                            if (hit_v[n]) begin
                                score_inc[n] = 1'b1;
                                duck_en_d[n] = 1'b0;
                                delay_d[n]   = FRAME_CNT_W'(RESPAWN_DELAY);
                            end else if (esc_v[n]) begin
                                lost         = lost + 2'd1;
                                duck_en_d[n] = 1'b0;
                                delay_d[n]   = FRAME_CNT_W'(RESPAWN_DELAY);
                            end
                        end else if (frame_tick && delay_q[n] != '0) begin
                            delay_d[n] = delay_q[n] - FRAME_CNT_W'(1);
                            if (delay_q[n] == FRAME_CNT_W'(1)) begin
                                respawn_d[n] = 1'b1;
                                duck_en_d[n] = 1'b1;
                            end
                        end
                    end
                    if (lives_q > LIVES_W'(lost)) begin
                        lives_d = lives_q - LIVES_W'(lost);
                    end else begin
                        lives_d = '0;
                    end
                end
            end
            GAMEOVER: begin
                if (frame_tick && hold_q != '0) begin
                    hold_d = hold_q - FRAME_CNT_W'(1);
                end
                if (key_evt && hold_q == '0) begin
                    state_d       = START;
                    is_start_d    = 1'b1;
                    is_gameover_d = 1'b0;
                    is_home_d     = 1'b0;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_sync_q    <= '0;
            frame_sync_q  <= '0;
            key_prev_q    <= 1'b0;
            frame_prev_q  <= 1'b0;
            state_q       <= START;
            is_start_q    <= 1'b1;
            is_gameover_q <= 1'b0;
            is_home_q     <= 1'b0;
            lives_q       <= '0;
            hold_q        <= '0;
            delay_q       <= '0;
            duck_en_q     <= '0;
            respawn_q     <= '0;
        end else begin
            key_sync_q    <= key_sync_d;
            frame_sync_q  <= frame_sync_d;
            key_prev_q    <= key_prev_d;
            frame_prev_q  <= frame_prev_d;
            state_q       <= state_d;
            is_start_q    <= is_start_d;
            is_gameover_q <= is_gameover_d;
            is_home_q     <= is_home_d;
            lives_q       <= lives_d;
            hold_q        <= hold_d;
            delay_q       <= delay_d;
            duck_en_q     <= duck_en_d;
            respawn_q     <= respawn_d;
        end
    end

    bcd_score_counter u_score (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .clear    (score_clr),
        .inc1     (score_inc[0]),
        .inc2     (score_inc[1]),
        .score_1  (score_1),
        .score_10 (score_10)
    );

    assign is_start    = is_start_q;
    assign is_gameover = is_gameover_q;
    assign is_home     = is_home_q;
    assign lives       = lives_q;
    assign is_score_1  = score_1;
    assign is_score_10 = score_10;
    assign respawn1    = respawn_q[0];
    assign respawn2    = respawn_q[1];
    assign duck_en1    = duck_en_q[0];
    assign duck_en2    = duck_en_q[1];

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Sequences game state for the duck-shooting display: title screen, play, game-over, return home.
- Maintains the two-digit BCD score and the lives count that the colour mapper renders.
- Issues respawn pulses to both duck motion blocks.
- Sits between the keypad/duck/scope logic and the colour mapper, driving its is_start, is_gameover, is_home, lives and score-digit inputs.

Parameters:
- LIVES_INIT, 3, lives loaded on entering PLAY (1..9).
- GAMEOVER_HOLD, 120, frames GAMEOVER must last before a key is accepted (1..255).
- RESPAWN_DELAY, 30, frames a hit or escaped duck stays gone before its respawn pulse (1..255).

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  VGA vertical-sync level; rising edge detected internally on Clk
- start_key  in  1  start/confirm key level, asynchronous to Clk
- hit1, hit2  in  1  one-Clk pulse: shot landed on duck 1/2
- escape1, escape2  in  1  one-Clk pulse: duck 1/2 left the playfield
- is_start  out  1  title screen active
- is_gameover  out  1  game-over overlay active
- is_home  out  1  home icon visible
- lives  out  4  remaining lives, binary
- is_score_1  out  4  score units digit, BCD
- is_score_10  out  4  score tens digit, BCD
- respawn1, respawn2  out  1  one-Clk pulse: restart duck 1/2
- duck_en1, duck_en2  out  1  duck 1/2 is alive and drawn

Behaviour:
- Reset (async assert, sync release) values:
  - State START; is_start=1; is_gameover=0; is_home=0.
  - lives=0; both score digits=0; respawn*=0; duck_en*=0.
  - All counters and edge detectors cleared.
- Input conditioning:
  - start_key passes through a 2-flop synchroniser, then a rising-edge detector (key_evt, 1 Clk).
  - frame_clk passes through a 2-flop synchroniser and edge detector (frame_tick).
- START:
  - On key_evt: load lives=LIVES_INIT; clear score to 00; go to PLAY.
  - Assert respawn1 and respawn2 in the first PLAY cycle; set duck_en1=duck_en2=1 in that same cycle.
  - is_start=0 from the PLAY cycle on.
- PLAY, per duck n:
  - hitn while duck_enn=1: score +1 (BCD) next cycle; duck_enn=0; load delay counter n with RESPAWN_DELAY.
  - escapen while duck_enn=1: lives -1 next cycle; duck_enn=0; load delay counter n.
  - hitn and escapen in the same cycle: the hit wins; no life is lost.
  - Events while duck_enn=0 are ignored.
  - Delay counter n decrements on frame_tick. On reaching 0: pulse respawnn for 1 Clk and set duck_enn=1 in that cycle.
  - Both ducks hit in the same cycle: score +2 (units 8->0 with carry, 9->1 with carry).
  - Both escape in the same cycle: lives -2, floored at 0.
- Score arithmetic:
  - Units 9 +1 -> 0 with tens +1.
  - 99 saturates: further hits leave 99.
  - Digits never leave 0..9.
- Lives reaching 0 (checked on the registered value):
  - Next cycle: go to GAMEOVER; duck_en*=0; respawn counters cleared; no respawn pulses.
  - is_gameover=1 and is_home=1.
  - Load hold counter with GAMEOVER_HOLD.
  - Score is frozen and stays displayed.
- GAMEOVER:
  - Hold counter decrements on frame_tick.
  - key_evt is ignored while the counter is non-zero.
  - key_evt once it is 0: go to START; is_gameover=0; is_home=0; is_start=1; score retained until the next START->PLAY.
- key_evt in PLAY is ignored (no pause).
- Reset asserted mid-PLAY or mid-GAMEOVER: immediate return to reset values. No respawn pulse is emitted on release.
- Respawn pulses occur only in PLAY and are never longer than 1 Clk.

Decomposition:
- Package game_pkg holds:
  - enum game_state_t {START, PLAY, GAMEOVER};
  - BCD digit typedef bcd_t (logic [3:0]);
  - constants LIVES_W=4, FRAME_CNT_W=8.
- One natural sub-module: bcd_score_counter.
  - Inputs: clear, inc1, inc2.
  - Outputs: two bcd_t digits.
  - Saturates at 99.
  - Instantiated once.

Test Plan:
- Start: Reset_n low then high; start_key pulse -> after sync latency is_start=0, lives=3, score 00, respawn1 and respawn2 both high for exactly 1 Clk in the same cycle.
- Scoring: 11 hit1 pulses, each after its duck respawns -> is_score_10=1, is_score_1=1. Preload 98, then simultaneous hit1+hit2 -> 99 (saturated), no digit >9.
- Lives: three escape1 events with RESPAWN_DELAY=2 -> lives 3,2,1,0; next cycle is_gameover=1, is_home=1, duck_en*=0; no respawn pulse afterwards.
- Hit vs escape collision: hit2 and escape2 in the same cycle -> score +1, lives unchanged, duck_en2=0. A second hit2 while duck_en2=0 -> no score change.
- Game-over hold: GAMEOVER_HOLD=4; start_key pulse after 2 frame ticks -> stays GAMEOVER. Pulse after 4 ticks -> is_start=1, is_gameover=0, is_home=0, score still displayed.
- Async reset mid-play: Reset_n low between Clk edges while lives=2 and score 37 -> outputs at reset values immediately, not at the next edge.
